// File: rtl/pipe_pkg.sv
// Shared encodings and opcode helpers for the Beta pipeline control unit.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pipe_pkg;

  // Instruction-register source select; values match defines.v.
  typedef enum logic [1:0] {
    IR_SRC_DATA   = 2'd0,
    IR_SRC_NOP    = 2'd1,
    IR_SRC_EXCEPT = 2'd2
  } ir_src_e;

  // Next-PC select.
  typedef enum logic [2:0] {
    PC_INC   = 3'd0,
    PC_BR    = 3'd1,
    PC_JMP   = 3'd2,
    PC_ILLOP = 3'd3,
    PC_XADR  = 3'd4,
    PC_RESET = 3'd5
  } pc_sel_e;

  localparam logic [5:0] OP_LD  = 6'b011000;
  localparam logic [5:0] OP_ST  = 6'b011001;
  localparam logic [5:0] OP_JMP = 6'b011011;
  localparam logic [5:0] OP_BEQ = 6'b011100;
  localparam logic [5:0] OP_BNE = 6'b011101;
  localparam logic [5:0] OP_LDR = 6'b011111;

  // R31 reads as zero, so it never carries a dependency.
  localparam logic [4:0] REG_ZERO = 5'd31;

  localparam logic [31:0] VEC_RESET = 32'h8000_0000;
  localparam logic [31:0] VEC_ILLOP = 32'h8000_0004;
  localparam logic [31:0] VEC_XADR  = 32'h8000_0008;

  // Beta opcode map:
  //   01xxxx : LD, ST, JMP, BEQ, BNE, LDR (011000/001/011/100/101/111)
  //   10xxxx : ALU ops, holes at x111
  //   11xxxx : ALU-with-constant ops, holes at x111
  function automatic logic is_legal_op(input logic [5:0] op);
    logic ok;
    case (op[5:4])
      2'b01:        ok = op[3] && (op[2:0] != 3'b010) && (op[2:0] != 3'b110);
      2'b10, 2'b11: ok = (op[2:0] != 3'b111);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LD) || (op == OP_LDR);
  endfunction

  // Register-register ALU ops read rb.
  function automatic logic reads_rb(input logic [5:0] op);
    return op[5:4] == 2'b10;
  endfunction

  // ST reads rc as the store data.
  function automatic logic reads_rc(input logic [5:0] op);
    return op == OP_ST;
  endfunction

endpackage

// File: rtl/pipe_ctl_hazard_detect.sv
// Load-use hazard detector: decode source registers vs load destinations in EX/MEM.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result feeds the stall logic in pipe_ctl.
// Ports: i_dec_op/i_dec_ra/i_dec_rb/i_dec_rc decode fields, i_ir_exec/i_ir_mem
//        {opcode, rc} of EX and MEM, o_hazard high when decode must wait.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [5:0]  i_dec_op,
  input  logic [4:0]  i_dec_ra,
  input  logic [4:0]  i_dec_rb,
  input  logic [4:0]  i_dec_rc,
  input  logic [10:0] i_ir_exec,
  input  logic [10:0] i_ir_mem,
  output logic        o_hazard
);

  logic w_use_ra;
  logic w_use_rb;
  logic w_use_rc;
  logic w_exec_hit;
  logic w_mem_hit;

  // LDR addresses relative to the PC, so its ra field is not a register read.
  assign w_use_ra = (i_dec_op != OP_LDR) && (i_dec_ra != REG_ZERO);
  assign w_use_rb = reads_rb(i_dec_op)   && (i_dec_rb != REG_ZERO);
  assign w_use_rc = reads_rc(i_dec_op)   && (i_dec_rc != REG_ZERO);

  function automatic logic dest_hit(input logic [10:0] ir_stage,
                                    input logic use_ra, input logic use_rb,
                                    input logic use_rc, input logic [4:0] ra,
                                    input logic [4:0] rb, input logic [4:0] rc);
    logic [4:0] dst;
    dst = ir_stage[4:0];
    return is_load(ir_stage[10:5]) && (dst != REG_ZERO) &&
           ((use_ra && (ra == dst)) || (use_rb && (rb == dst)) ||
            (use_rc && (rc == dst)));
  endfunction

  assign w_exec_hit = dest_hit(i_ir_exec, w_use_ra, w_use_rb, w_use_rc,
                               i_dec_ra, i_dec_rb, i_dec_rc);
  assign w_mem_hit  = dest_hit(i_ir_mem, w_use_ra, w_use_rb, w_use_rc,
                               i_dec_ra, i_dec_rb, i_dec_rc);

  assign o_hazard = w_exec_hit || w_mem_hit;

endmodule

// File: rtl/pipe_ctl.sv
// Beta pipeline control: stalls, annulment, IR sources and next-PC select.
// Latency: control outputs and irq_ack combinational (zero cycles); stall_cnt registered.
// Backpressure: stall freezes PC and fetch/decode while a load result is not yet bypassable.
// Ports: clk/rst (sync, active-high); ir_dec, pc_dec_sup, ir_exec, ir_mem, zr, irq in;
//        stall, ir_src_if, ir_src_dec, pc_sel, irq_ack, stall_cnt out.
module pipe_ctl
  import pipe_pkg::*;
#(
  parameter int SHADOW_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir_dec,
  input  logic        pc_dec_sup,
  input  logic [10:0] ir_exec,
  input  logic [10:0] ir_mem,
  input  logic        zr,
  input  logic        irq,
  output logic        stall,
  output logic [1:0]  ir_src_if,
  output logic [1:0]  ir_src_dec,
  output logic [2:0]  pc_sel,
  output logic        irq_ack,
  output logic [31:0] stall_cnt
);

  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_SHADOW = 1'b1;
  localparam logic [7:0] SHADOW_LOAD = 8'(SHADOW_CYCLES - 1);

  logic        r_state;
  logic [7:0]  r_shadow_cnt;
  logic        r_irq_pend;
  logic [31:0] r_stall_cnt;

  logic [5:0]  w_op;
  logic        w_illegal;
  logic        w_hazard;
  logic        w_irq_take;
  logic        w_inject;
  logic        w_taken;
  logic [2:0]  w_br_sel;
  logic        w_unused_lo;

  assign w_op        = ir_dec[31:26];
  assign w_illegal   = ~is_legal_op(w_op);
  // Literal/offset bits play no part in control decisions.
  assign w_unused_lo = ^ir_dec[10:0];

  hazard_detect u_hazard (
    .i_dec_op  (w_op),
    .i_dec_ra  (ir_dec[20:16]),
    .i_dec_rb  (ir_dec[15:11]),
    .i_dec_rc  (ir_dec[25:21]),
    .i_ir_exec (ir_exec),
    .i_ir_mem  (ir_mem),
    .o_hazard  (w_hazard)
  );

  // Interrupts are only taken from user mode, outside the post-exception window.
  assign w_irq_take = r_irq_pend && (r_state == ST_RUN) && !pc_dec_sup;
  assign w_inject   = w_illegal || w_irq_take;

  always_comb begin
    w_taken  = 1'b0;
    w_br_sel = PC_BR;
    case (w_op)
      OP_JMP: begin
        w_taken  = 1'b1;
        w_br_sel = PC_JMP;
      end
      OP_BEQ:  w_taken = zr;
      OP_BNE:  w_taken = ~zr;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    ir_src_if  = IR_SRC_DATA;
    ir_src_dec = IR_SRC_DATA;
    pc_sel     = PC_INC;
    irq_ack    = 1'b0;
    if (rst) begin
      ir_src_if  = IR_SRC_NOP;
      ir_src_dec = IR_SRC_NOP;
      pc_sel     = PC_RESET;
    end else if (w_illegal) begin
      ir_src_if  = IR_SRC_NOP;
      ir_src_dec = IR_SRC_EXCEPT;
      pc_sel     = PC_ILLOP;
    end else if (w_irq_take) begin
      // Any pending load-use stall is moot: the decode instruction is replaced.
      ir_src_if  = IR_SRC_NOP;
      ir_src_dec = IR_SRC_EXCEPT;
      pc_sel     = PC_XADR;
      irq_ack    = 1'b1;
    end else if (w_hazard) begin
      // Bubble into execute; a branch in decode is re-evaluated once unstalled.
      stall      = 1'b1;
      ir_src_dec = IR_SRC_NOP;
    end else if (w_taken) begin
      ir_src_if  = IR_SRC_NOP;
      pc_sel     = w_br_sel;
    end
  end

  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_shadow_cnt <= 8'd0;
      r_irq_pend   <= 1'b0;
      r_stall_cnt  <= 32'd0;
    end else begin
      // A new request arriving in the ack cycle stays pending.
      r_irq_pend  <= irq | (r_irq_pend & ~irq_ack);
      r_stall_cnt <= r_stall_cnt + {31'd0, stall};
      if (w_inject) begin
        r_state      <= ST_SHADOW;
        r_shadow_cnt <= SHADOW_LOAD;
      end else if (r_state == ST_SHADOW) begin
        if (r_shadow_cnt == 8'd0) begin
          r_state <= ST_RUN;
        end else begin
          r_shadow_cnt <= r_shadow_cnt - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctl.sv
module tb_pipe_ctl;

  localparam int SHADOW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir_dec = '0;
  logic        pc_dec_sup = 1'b0;
  logic [10:0] ir_exec = '0;
  logic [10:0] ir_mem = '0;
  logic        zr = 1'b0;
  logic        irq = 1'b0;
  logic        stall;
  logic [1:0]  ir_src_if;
  logic [1:0]  ir_src_dec;
  logic [2:0]  pc_sel;
  logic        irq_ack;
  logic [31:0] stall_cnt;

  pipe_ctl #(.SHADOW_CYCLES(SHADOW)) dut (
    .clk(clk), .rst(rst), .ir_dec(ir_dec), .pc_dec_sup(pc_dec_sup),
    .ir_exec(ir_exec), .ir_mem(ir_mem), .zr(zr), .irq(irq),
    .stall(stall), .ir_src_if(ir_src_if), .ir_src_dec(ir_src_dec),
    .pc_sel(pc_sel), .irq_ack(irq_ack), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  wire [8:0] act = {stall, ir_src_if, ir_src_dec, pc_sel, irq_ack};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: pending request, remaining shadow cycles (0 = free to interrupt).
  bit          m_pend = 0;
  int          m_left = 0;
  int unsigned m_stalls = 0;
  logic [8:0]  exp_vec;
  bit          e_stall, e_ack, e_inject;

  int legal_ops[$] = '{24, 25, 27, 28, 29, 31,
                       32, 33, 34, 35, 36, 37, 38, 40, 41, 42, 43, 44, 45, 46,
                       48, 49, 50, 51, 52, 53, 54, 56, 57, 58, 59, 60, 61, 62};

  localparam int ADD = 32, LD = 24, ST = 25, JMP = 27, BEQ = 28, BNE = 29, LDR = 31;

  function automatic logic [31:0] mk(int op, int rc, int ra, int rb);
    return {op[5:0], rc[4:0], ra[4:0], rb[4:0], 11'h5a5};
  endfunction

  function automatic logic [10:0] ex(int op, int rc);
    return {op[5:0], rc[4:0]};
  endfunction

  function automatic bit op_legal(int op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1;
    return 0;
  endfunction

  function automatic void model_eval();
    int op;
    int srcs[$];
    int dsts[$];
    bit hz;
    bit taken;
    int pc;
    op = int'(ir_dec[31:26]);
    hz = 0; taken = 0; pc = 1;
    if (op != LDR && ir_dec[20:16] != 31) srcs.push_back(int'(ir_dec[20:16]));
    if (op >= 32 && op < 48 && ir_dec[15:11] != 31) srcs.push_back(int'(ir_dec[15:11]));
    if (op == ST && ir_dec[25:21] != 31) srcs.push_back(int'(ir_dec[25:21]));
    if ((ir_exec[10:5] == LD || ir_exec[10:5] == LDR) && ir_exec[4:0] != 31)
      dsts.push_back(int'(ir_exec[4:0]));
    if ((ir_mem[10:5] == LD || ir_mem[10:5] == LDR) && ir_mem[4:0] != 31)
      dsts.push_back(int'(ir_mem[4:0]));
    foreach (srcs[i]) foreach (dsts[j]) if (srcs[i] == dsts[j]) hz = 1;
    if (op == JMP) begin taken = 1; pc = 2; end
    if (op == BEQ && zr) taken = 1;
    if (op == BNE && !zr) taken = 1;
    e_stall = 0; e_ack = 0; e_inject = 0;
    if (rst) exp_vec = {1'b0, 2'd1, 2'd1, 3'd5, 1'b0};
    else if (!op_legal(op)) begin
      exp_vec = {1'b0, 2'd1, 2'd2, 3'd3, 1'b0}; e_inject = 1;
    end else if (m_pend && m_left == 0 && !pc_dec_sup) begin
      exp_vec = {1'b0, 2'd1, 2'd2, 3'd4, 1'b1}; e_inject = 1; e_ack = 1;
    end else if (hz) begin
      exp_vec = {1'b1, 2'd0, 2'd1, 3'd0, 1'b0}; e_stall = 1;
    end else if (taken) exp_vec = {1'b0, 2'd1, 2'd0, 3'(pc), 1'b0};
    else exp_vec = 9'd0;
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_pend = 0; m_left = 0; m_stalls = 0;
    end else begin
      if (e_stall) m_stalls++;
      m_pend = irq || (m_pend && !e_ack);
      if (e_inject) m_left = SHADOW;
      else if (m_left > 0) m_left--;
    end
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    model_eval();
    model_step();
    #1;
  endtask

  task automatic step_in(logic [31:0] d, logic [10:0] e, logic [10:0] m,
                         logic z, logic s, logic q);
    ir_dec = d; ir_exec = e; ir_mem = m; zr = z; pc_dec_sup = s; irq = q;
    @(negedge clk);
    model_eval();
  endtask

  task automatic apply_reset();
    rst = 1;
    step_in(mk(ADD, 31, 31, 31), ex(ADD, 31), ex(ADD, 31), 0, 0, 0);
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int c = 0; c < 3; c++) begin
      step_in($urandom, 11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom), 1);
      n_checks++;
      if (act !== 9'b0_01_01_101_0)
        $display("FAIL reset[%0d] ctl got=%b want=%b", c, act, 9'b0_01_01_101_0);
      else n_pass++;
      if (c > 0) begin
        n_checks++;
        if (stall_cnt !== 32'd0) $display("FAIL reset_cnt[%0d] got=%0d want=0", c, stall_cnt);
        else n_pass++;
      end
      next_cycle();
    end
    rst = 0;
  endtask

  task automatic test_load_use();
    logic [31:0] d[6];
    logic [10:0] e[6];
    logic [10:0] m[6];
    apply_reset();
    d[0] = mk(ADD, 2, 1, 3);  e[0] = ex(LD, 1);    m[0] = ex(ADD, 31);
    d[1] = mk(ADD, 2, 1, 3);  e[1] = ex(ADD, 31);  m[1] = ex(LD, 1);
    d[2] = mk(ADD, 2, 1, 3);  e[2] = ex(ADD, 31);  m[2] = ex(ADD, 31);
    d[3] = mk(LDR, 5, 2, 0);  e[3] = ex(LD, 2);    m[3] = ex(ADD, 31);
    d[4] = mk(ST, 4, 31, 0);  e[4] = ex(LDR, 4);   m[4] = ex(ADD, 31);
    d[5] = mk(ADD, 1, 31, 7); e[5] = ex(LD, 31);   m[5] = ex(LD, 7);
    for (int c = 0; c < 6; c++) begin
      step_in(d[c], e[c], m[c], 0, 0, 0);
      n_checks++;
      if (act !== exp_vec) $display("FAIL load_use[%0d] ctl got=%b want=%b", c, act, exp_vec);
      else n_pass++;
      if (c == 3) begin
        n_checks++;
        if (stall_cnt !== 32'd2) $display("FAIL load_use_cnt got=%0d want=2", stall_cnt);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_branch();
    int op[6]  = '{BEQ, BNE, BNE, BEQ, JMP, BEQ};
    bit z[6]   = '{1, 1, 0, 0, 0, 1};
    int pcx[6] = '{1, 0, 1, 0, 2, 0};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      step_in(mk(op[c], 0, 3, 0), (c == 5) ? ex(LD, 3) : ex(ADD, 31), ex(ADD, 31), z[c], 0, 0);
      n_checks++;
      if (act !== exp_vec || pc_sel !== 3'(pcx[c]))
        $display("FAIL branch[%0d] ctl got=%b want=%b pc_want=%0d", c, act, exp_vec, pcx[c]);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_illop_vs_irq();
    bit q[6]   = '{1, 0, 0, 0, 0, 0};
    bit ack[6] = '{0, 0, 0, 0, 1, 0};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      step_in((c == 1) ? mk(0, 1, 2, 3) : mk(ADD, 31, 31, 31), ex(ADD, 31), ex(ADD, 31), 0, 0, q[c]);
      n_checks++;
      if (act !== exp_vec || irq_ack !== ack[c])
        $display("FAIL illop[%0d] ctl got=%b want=%b ack_want=%0d", c, act, exp_vec, ack[c]);
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if (ir_src_dec !== 2'd2 || pc_sel !== 3'd3)
          $display("FAIL illop_vec got dec=%0d pc=%0d want dec=2 pc=3", ir_src_dec, pc_sel);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_irq_shadow();
    bit q[6]   = '{1, 1, 0, 0, 0, 0};
    bit ack[6] = '{0, 1, 0, 0, 1, 0};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      step_in(mk(ADD, 2, 1, 3), (c == 1) ? ex(LD, 1) : ex(ADD, 31), ex(ADD, 31), 0, 0, q[c]);
      n_checks++;
      if (act !== exp_vec || irq_ack !== ack[c])
        $display("FAIL irq[%0d] ctl got=%b want=%b ack_want=%0d", c, act, exp_vec, ack[c]);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_supervisor();
    bit sup[7] = '{1, 1, 1, 1, 1, 0, 0};
    bit ack[7] = '{0, 0, 0, 0, 0, 1, 0};
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      step_in(mk(ADD, 31, 31, 31), ex(ADD, 31), ex(ADD, 31), 0, sup[c], c == 0);
      n_checks++;
      if (act !== exp_vec || irq_ack !== ack[c])
        $display("FAIL super[%0d] ctl got=%b want=%b ack_want=%0d", c, act, exp_vec, ack[c]);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_stall();
    bit r[4] = '{0, 1, 1, 0};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      rst = r[c];
      step_in(mk(ADD, 2, 1, 3), (c == 3) ? ex(ADD, 31) : ex(LD, 1),
              (c == 3) ? ex(LD, 1) : ex(ADD, 31), 0, 0, 0);
      n_checks++;
      if (act !== exp_vec || stall_cnt !== m_stalls)
        $display("FAIL rst_stall[%0d] ctl got=%b/%0d want=%b/%0d", c, act, stall_cnt, exp_vec, m_stalls);
      else n_pass++;
      if (c == 2) begin
        n_checks++;
        if (stall_cnt !== 32'd0 || pc_sel !== 3'd5)
          $display("FAIL rst_stall_clr got cnt=%0d pc=%0d want cnt=0 pc=5", stall_cnt, pc_sel);
        else n_pass++;
      end
      next_cycle();
    end
    rst = 0;
  endtask

  function automatic int pick_reg();
    int r;
    case ($urandom_range(3))
      0: r = 1;
      1: r = 2;
      2: r = 3;
      default: r = 31;
    endcase
    return r;
  endfunction

  function automatic int pick_op();
    if ($urandom_range(99) < 75) return legal_ops[$urandom_range(legal_ops.size() - 1)];
    return int'($urandom_range(63));
  endfunction

  function automatic logic [10:0] pick_stage();
    int op;
    op = ($urandom_range(1) == 0) ? (($urandom_range(1) == 0) ? LD : LDR) : pick_op();
    return ex(op, pick_reg());
  endfunction

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(99) < 2);
      step_in(mk(pick_op(), pick_reg(), pick_reg(), pick_reg()), pick_stage(), pick_stage(),
              1'($urandom), $urandom_range(99) < 20, $urandom_range(99) < 12);
      n_checks++;
      if (act !== exp_vec || stall_cnt !== m_stalls)
        $display("FAIL random[%0d] ctl got=%b/%0d want=%b/%0d", c, act, stall_cnt, exp_vec, m_stalls);
      else n_pass++;
      next_cycle();
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_illop_vs_irq();
    test_irq_shadow();
    test_supervisor();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
